// File: rtl/cfg_spi_writer.sv
// cfg_spi_writer: serial configuration front end for the voice synth.
// Receives 16-bit write frames over a 3-wire SPI-style link (mode 0, MSB
// first). Each frame is {5 ignored bits, addr[2:0], data[7:0]}. Accepted
// frames are buffered in a small FIFO and replayed as single-cycle, one-hot
// byte-enable writes, with strobes spaced at least WRITE_GAP cycles apart.
//
// Ports:
//   clk, rst_n    system clock, synchronous active-low reset
//   ena           design enable; low blocks strobes, reception continues
//   spi_sck       serial clock (async, at most clk/4)
//   spi_cs_n      frame select, active low (async)
//   spi_mosi      serial data (async)
//   cfg_out       config data byte; valid in the strobe cycle, then held
//   cfg_en        one-hot byte enable, high for one cycle per write
//   overflow      sticky: a complete frame was dropped, FIFO full
//   bad_addr      sticky: a frame with addr >= NUM_REGS was discarded
//   busy          FIFO non-empty or a frame in progress
module cfg_spi_writer #(
   parameter int unsigned NUM_REGS   = 6,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WRITE_GAP  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       spi_sck,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic [7:0] cfg_out,
   output logic [7:0] cfg_en,
   output logic       overflow,
   output logic       bad_addr,
   output logic       busy
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [GW-1:0] GAP_LOAD = GW'(WRITE_GAP - 1);

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
   } wr_t;

   logic [1:0]    sck_sync;
   logic [1:0]    cs_sync;
   logic [1:0]    mosi_sync;
   logic          sck_prev;
   logic [3:0]    bit_cnt;
   // The top five frame bits are ignored, so only the low 11 bits are kept.
   logic [10:0]   shift_q;
   logic          frame_vld;
   wr_t           mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [GW-1:0] gap_cnt;
   logic [7:0]    cfg_hold;

   wr_t  frame;
   wr_t  head;
   logic sck_rise;
   logic frame_end;
   logic addr_ok;
   logic full;
   logic push;
   logic pop;

   // Two-flop synchronizers plus previous synced sck for edge detect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_sync  <= 2'b11;
         cs_sync   <= 2'b11;
         mosi_sync <= 2'b00;
         sck_prev  <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[0], spi_sck};
         cs_sync   <= {cs_sync[0], spi_cs_n};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         sck_prev  <= sck_sync[1];
      end
   end

   assign sck_rise  = sck_sync[1] & ~sck_prev;
   assign frame_end = sck_rise & ~cs_sync[1] & (bit_cnt == 4'd15);

   // Bit framing; frame_vld marks the cycle after the 16th sampled bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt   <= 4'd0;
         shift_q   <= 11'd0;
         frame_vld <= 1'b0;
      end else begin
         frame_vld <= frame_end;
         if (cs_sync[1]) begin
            bit_cnt <= 4'd0;
         end else if (sck_rise) begin
            shift_q <= {shift_q[9:0], mosi_sync[1]};
            bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

   // Frame disposition and issue decision.
   always_comb begin
      frame   = wr_t'(shift_q);
      head    = mem[rd_ptr];
      addr_ok = 32'(frame.addr) < NUM_REGS;
      full    = (count == FULL_CNT);
      push    = frame_vld & addr_ok & ~full;
      pop     = rst_n & ena & (count != '0) & (gap_cnt == '0);
   end

   // FIFO storage needs no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= frame;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Gap counter keeps running while ena is low; only pops are gated.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gap_cnt <= '0;
      end else if (pop) begin
         gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != '0) begin
         gap_cnt <= gap_cnt - GW'(1);
      end
   end

   // Sticky error flags and held data byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         bad_addr <= 1'b0;
         cfg_hold <= 8'd0;
      end else begin
         if (frame_vld & ~addr_ok) begin
            bad_addr <= 1'b1;
         end
         if (frame_vld & addr_ok & full) begin
            overflow <= 1'b1;
         end
         if (pop) begin
            cfg_hold <= head.data;
         end
      end
   end

   // Strobe is presented in the pop cycle itself; data then stays held.
   always_comb begin
      cfg_en  = pop ? (8'd1 << head.addr) : 8'd0;
      cfg_out = pop ? head.data : cfg_hold;
      busy    = (count != '0) | frame_vld | (~cs_sync[1] & (bit_cnt != 4'd0));
   end

endmodule

// File: tb/tb_cfg_spi_writer.sv
module tb_cfg_spi_writer;

   localparam int unsigned NUM_REGS   = 6;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned WRITE_GAP  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       spi_sck = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_mosi = 1'b0;
   logic [7:0] cfg_out;
   logic [7:0] cfg_en;
   logic       overflow;
   logic       bad_addr;
   logic       busy;

   cfg_spi_writer #(
      .NUM_REGS   (NUM_REGS),
      .FIFO_DEPTH (FIFO_DEPTH),
      .WRITE_GAP  (WRITE_GAP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .spi_sck  (spi_sck),
      .spi_cs_n (spi_cs_n),
      .spi_mosi (spi_mosi),
      .cfg_out  (cfg_out),
      .cfg_en   (cfg_en),
      .overflow (overflow),
      .bad_addr (bad_addr),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference model: ordered list of writes the synth must see, plus flags.
   logic [10:0] exp_q[$];
   logic        bad_exp = 1'b0;
   logic        ovf_exp = 1'b0;

   int          n_strobes = 0;
   int          last_strobe_cyc = 0;
   int          prev_strobe_cyc = 0;
   bit          have_prev = 1'b0;
   int          last_rise_cyc = 0;
   logic [7:0]  last_en = 8'h00;
   logic [10:0] mon_e;
   logic [7:0]  mon_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Every strobe must be the next expected write, spaced >= WRITE_GAP.
   always @(negedge clk) begin
      if (cfg_en !== 8'h00) begin
         n_strobes++;
         last_en = cfg_en;
         last_strobe_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe cfg_en=%02h cfg_out=%02h cyc=%0d", cfg_en, cfg_out, cyc);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_en = 8'd1 << mon_e[10:8];
            chk("strobe_en", 32'(cfg_en), 32'(mon_en));
            chk("strobe_data", 32'(cfg_out), 32'(mon_e[7:0]));
         end
         if (have_prev) chk("strobe_spacing_ok", 32'((cyc - prev_strobe_cyc) >= int'(WRITE_GAP)), 32'd1);
         prev_strobe_cyc = cyc;
         have_prev = 1'b1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b);
      spi_mosi = b;
      tick(4);
      spi_sck = 1'b1;
      last_rise_cyc = cyc;
      tick(4);
      spi_sck = 1'b0;
   endtask

   task automatic cs_lo();
      spi_cs_n = 1'b0;
      tick(4);
   endtask

   task automatic cs_hi();
      tick(4);
      spi_cs_n = 1'b1;
      tick(6);
   endtask

   task automatic send_frame(input logic [15:0] f);
      for (int i = 15; i >= 0; i--) spi_bit(f[i]);
   endtask

   // Disposition of a complete frame, decided from the rules alone.
   task automatic model_frame(input logic [15:0] f);
      if (32'(f[10:8]) >= NUM_REGS) bad_exp = 1'b1;
      else if (exp_q.size() >= FIFO_DEPTH) ovf_exp = 1'b1;
      else exp_q.push_back(f[10:0]);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      exp_q.delete();
      bad_exp = 1'b0;
      ovf_exp = 1'b0;
      have_prev = 1'b0;
   endtask

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  en;
      logic [7:0]  out;
      logic        bad;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int s0;
      logic [15:0] f;
      int nf;

      vecs[0] = '{16'h0305, 8'h08, 8'h05, 1'b0};
      vecs[1] = '{16'h0600, 8'h00, 8'h05, 1'b1};
      vecs[2] = '{16'h05FF, 8'h20, 8'hFF, 1'b1};
      vecs[3] = '{16'hF8AA, 8'h01, 8'hAA, 1'b1};
      vecs[4] = '{16'h0700, 8'h00, 8'hAA, 1'b1};
      vecs[5] = '{16'h0211, 8'h04, 8'h11, 1'b1};

      // Reset state
      tick(3);
      rst_n = 1'b1;
      tick(1);
      chk("rst_cfg_out", 32'(cfg_out), 32'h0);
      chk("rst_cfg_en", 32'(cfg_en), 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      chk("rst_bad_addr", 32'(bad_addr), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      // Table-driven single frames
      ena = 1'b1;
      for (int i = 0; i < 6; i++) begin
         s0 = n_strobes;
         model_frame(vecs[i].frame);
         cs_lo();
         send_frame(vecs[i].frame);
         cs_hi();
         tick(10);
         chk($sformatf("vec%0d_strobes", i), 32'(n_strobes - s0), (vecs[i].en != 8'h00) ? 32'd1 : 32'd0);
         if (vecs[i].en != 8'h00) chk($sformatf("vec%0d_en", i), 32'(last_en), 32'(vecs[i].en));
         chk($sformatf("vec%0d_out", i), 32'(cfg_out), 32'(vecs[i].out));
         chk($sformatf("vec%0d_bad", i), 32'(bad_addr), 32'(vecs[i].bad));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
         if (i == 0) chk("latency_d_plus_2", 32'(last_strobe_cyc - last_rise_cyc), 32'd4);
      end
      chk("table_drained", 32'(exp_q.size()), 32'd0);

      // Three back-to-back frames in one cs_n window
      s0 = n_strobes;
      cs_lo();
      model_frame(16'h00A1); send_frame(16'h00A1);
      model_frame(16'h01B2); send_frame(16'h01B2);
      model_frame(16'h02C3); send_frame(16'h02C3);
      cs_hi();
      tick(10);
      chk("b2b_strobes", 32'(n_strobes - s0), 32'd3);
      chk("b2b_last_out", 32'(cfg_out), 32'hC3);

      // cs_n raised after 9 bits, then a full frame
      s0 = n_strobes;
      f = 16'h0ABC;
      cs_lo();
      for (int i = 15; i >= 7; i--) spi_bit(f[i]);
      tick(4);
      chk("partial_busy", 32'(busy), 32'h1);
      cs_hi();
      chk("partial_busy_drop", 32'(busy), 32'h0);
      model_frame(16'h0142);
      cs_lo();
      send_frame(16'h0142);
      cs_hi();
      tick(10);
      chk("partial_strobes", 32'(n_strobes - s0), 32'd1);
      chk("partial_en", 32'(last_en), 32'h02);
      chk("partial_out", 32'(cfg_out), 32'h42);

      // ena low, five frames into a four-deep FIFO
      ena = 1'b0;
      s0 = n_strobes;
      cs_lo();
      for (int i = 0; i < 5; i++) begin
         f = {8'h00 | 8'(i % NUM_REGS), 8'h10 + 8'(i)};
         model_frame(f);
         send_frame(f);
      end
      cs_hi();
      tick(4);
      chk("ovf_flag", 32'(overflow), 32'h1);
      chk("ovf_model_flag", 32'(overflow), 32'(ovf_exp));
      chk("ovf_no_strobe", 32'(n_strobes - s0), 32'd0);
      chk("ovf_busy", 32'(busy), 32'h1);
      ena = 1'b1;
      tick(30);
      chk("ovf_drain_strobes", 32'(n_strobes - s0), 32'd4);
      chk("ovf_last_out", 32'(cfg_out), 32'h13);
      chk("ovf_busy_after", 32'(busy), 32'h0);

      // Reset with two entries queued
      ena = 1'b0;
      s0 = n_strobes;
      cs_lo();
      model_frame(16'h0011); send_frame(16'h0011);
      model_frame(16'h0122); send_frame(16'h0122);
      cs_hi();
      tick(3);
      chk("pre_rst_busy", 32'(busy), 32'h1);
      pulse_reset();
      ena = 1'b1;
      tick(20);
      chk("rst_q_no_strobe", 32'(n_strobes - s0), 32'd0);
      chk("rst_q_cfg_out", 32'(cfg_out), 32'h0);
      chk("rst_q_cfg_en", 32'(cfg_en), 32'h0);
      chk("rst_q_overflow", 32'(overflow), 32'h0);
      chk("rst_q_bad_addr", 32'(bad_addr), 32'h0);
      chk("rst_q_busy", 32'(busy), 32'h0);
      model_frame(16'h047E);
      cs_lo();
      send_frame(16'h047E);
      cs_hi();
      tick(10);
      chk("post_rst_strobes", 32'(n_strobes - s0), 32'd1);
      chk("post_rst_en", 32'(last_en), 32'h10);
      chk("post_rst_out", 32'(cfg_out), 32'h7E);

      // Randomized frames with occasional aborted tails
      for (int w = 0; w < 10; w++) begin
         cs_lo();
         nf = int'($urandom_range(1, 3));
         for (int k = 0; k < nf; k++) begin
            f = {5'($urandom), 3'($urandom_range(0, 7)), 8'($urandom)};
            model_frame(f);
            send_frame(f);
         end
         if ($urandom_range(0, 2) == 0) begin
            f = 16'($urandom);
            for (int i = int'($urandom_range(1, 15)); i > 0; i--) spi_bit(f[i]);
         end
         cs_hi();
      end
      tick(20);
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      chk("rand_bad_addr", 32'(bad_addr), 32'(bad_exp));
      chk("rand_overflow", 32'(overflow), 32'(ovf_exp));
      chk("rand_busy", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cfg_spi_writer.md
# cfg_spi_writer

Serial configuration front end for the voice synth. Receives 16-bit write frames over a 3-wire SPI-style link (mode 0, MSB first), buffers them in a small FIFO, and replays them as single-cycle byte writes on the synth's 8-bit config data bus with a one-hot byte-enable strobe. Writes are paced so that consecutive strobes are spaced by at least one full synth update cycle. It drives the synth's config data input (`uio_in` side) and byte enables (`ui_in` side) from a host that only has a few pins.

## Interface
- `NUM_REGS`, 6: number of valid config byte addresses (0..NUM_REGS-1); max 8.
- `FIFO_DEPTH`, 4: write-buffer entries; power of two, ≥2.
- `WRITE_GAP`, 4: minimum clk cycles from one strobe to the next; ≥1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active low.
- `ena`  in  1  design enable; when low, no strobes are issued and reception continues.
- `spi_sck`  in  1  serial clock; asynchronous to `clk`; at most clk/4.
- `spi_cs_n`  in  1  frame select, active low; asynchronous.
- `spi_mosi`  in  1  serial data; asynchronous.
- `cfg_out`  out  8  config data byte; valid in the strobe cycle and held until the next strobe.
- `cfg_en`  out  8  one-hot byte enable; bit `addr` is high for exactly one cycle per write.
- `overflow`  out  1  sticky; a complete frame was dropped because the FIFO was full.
- `bad_addr`  out  1  sticky; a frame with `addr >= NUM_REGS` was discarded.
- `busy`  out  1  FIFO non-empty, or a frame in progress (`cs_n` low with bit count ≠ 0).

## Operation
- Sync: two-flop synchronizers on `spi_sck`, `spi_cs_n` and `spi_mosi`. Edge detect on synced sck: cycle D is the first cycle with synced sck=1 and previous synced sck=0.
- Framing: a synced `cs_n` high holds the 4-bit bit counter at 0 and discards any partial frame. On each D with synced `cs_n` low, shift synced mosi into a 16-bit shift register and increment the counter modulo 16.
- Frame format: [15:11] ignored, [10:8] `addr`, [7:0] `data`.
- On the 16th bit: the frame is complete. Several frames may follow back-to-back within one `cs_n` low period; the counter wraps to 0 and the next bit starts a new frame.
- Frame disposition: `addr >= NUM_REGS` → discard and set `bad_addr`. Otherwise, if the FIFO is full → discard and set `overflow`. Otherwise push {addr, data}.
- Issue: pop when the FIFO is non-empty, `ena`=1 and the gap counter is 0. In the pop cycle, `cfg_out`=data and `cfg_en`=1<<addr. The gap counter is loaded with WRITE_GAP-1 and decrements to 0.
- Push and pop may occur in the same cycle; occupancy is unchanged. Push when full is never blocked by a same-cycle pop. Full is evaluated before the pop.
- `cs_n` rising mid-frame: partial bits are dropped and nothing is pushed. Entries already in the FIFO are unaffected.
- `ena` low mid-gap: the gap counter keeps counting; only pops are blocked.

## Timing
- Reset values: `cfg_out`=0, `cfg_en`=0, `overflow`=0, `bad_addr`=0, `busy`=0. FIFO empty, gap counter 0, bit counter 0, shift register 0, synchronizers 1 for sck/cs_n and 0 for mosi.
- Reset mid-frame or with the FIFO non-empty: all state is lost and no strobe is issued.
- Latency: 16th-bit D at cycle D. Push at the end of D+1. Earliest strobe in cycle D+2 (FIFO empty, gap 0, `ena`=1).
- Pin to D: 2–3 clk cycles after the sck pin rises.
- Strobe spacing: ≥ WRITE_GAP cycles between strobe cycles. WRITE_GAP=1 allows back-to-back strobes.
- `cfg_en` is high for 1 cycle per accepted frame, never more than 1 bit at a time. It is 0 in all other cycles.
- Flags assert at the end of D+1 of the offending frame and stay set until reset.

## Test plan
- Single write 0x0305 (addr 3, data 0x05), sck = clk/8, ena=1 → one strobe: `cfg_en`=0x08, `cfg_out`=0x05, exactly 2 cycles after the 16th D; `busy` falls after the strobe.
- Three back-to-back frames in one `cs_n` window (addr 0/1/2, data 0xA1/0xB2/0xC3), WRITE_GAP=4 → strobes 0x01/0x02/0x04 in order with matching data, spaced ≥4 cycles.
- Frame with addr 6 → no strobe, `bad_addr`=1, FIFO unchanged; following valid frame addr 5 → strobe `cfg_en`=0x20.
- `ena`=0, send 5 frames with FIFO_DEPTH=4 → `overflow`=1. Raise `ena` → exactly 4 strobes carrying the first 4 frames.
- `cs_n` raised after 9 bits, then a full frame 0x0142 → only one strobe: `cfg_en`=0x02, `cfg_out`=0x42.
- `rst_n` low for 1 cycle with 2 entries queued → no further strobes, all outputs 0, flags cleared; the next frame is processed normally.
